// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a TX FIFO and sticky overflow status.
// Define UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
   parameter logic [15:0] p_BASE_ADDR    = 16'h0400,
   parameter int          p_CLKS_PER_BIT = 16,
   parameter int          p_FIFO_DEPTH   = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_addr,
   input  logic [15:0] i_wr_data,
   input  logic        i_wr_en,
   output logic [15:0] o_rd_data,
   output logic        o_tx
);
   localparam int AW = $clog2(p_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0] status_addr = p_BASE_ADDR + 16'd1;
   localparam logic [15:0] last_tick = 16'(p_CLKS_PER_BIT - 1);
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t state, state_n;
   logic [15:0] timer;
   logic [2:0] idx;
   logic [7:0] shreg;
   logic [7:0] mem [p_FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic overflow, full, empty, tick, pop, push, accept, clr;
   logic unused_hi;
   assign unused_hi = ^i_wr_data[15:8];
   assign full = count == CW'(p_FIFO_DEPTH);
   assign empty = count == '0;
   assign tick = timer == last_tick;
   assign push = i_wr_en && i_addr == p_BASE_ADDR;
   assign clr = i_wr_en && i_addr == status_addr;
   // a full FIFO still takes a byte when the FSM pops in the same cycle
   assign accept = push && (!full || pop);
   assign o_rd_data = i_addr == status_addr ? {12'b0, overflow, state != IDLE, empty, full} : 16'h0000;
   always_comb begin
      state_n = state;
      pop = 1'b0;
      o_tx = 1'b1;
      case (state)
         IDLE: begin
            pop = !empty;
            state_n = empty ? IDLE : START;
         end
         START: begin
            o_tx = 1'b0;
            state_n = tick ? DATA : START;
         end
`ifdef UART_PARITY_EN
         DATA: begin
            o_tx = shreg[idx];
            state_n = (tick && idx == 3'd7) ? PARITY : DATA;
         end
         PARITY: begin
            o_tx = ^shreg;
            state_n = tick ? STOP : PARITY;
         end
`else
         DATA: begin
            o_tx = shreg[idx];
            state_n = (tick && idx == 3'd7) ? STOP : DATA;
         end
`endif
         STOP: begin
            pop = tick && !empty;
            state_n = tick ? (empty ? IDLE : START) : STOP;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         timer <= '0;
         idx <= '0;
         shreg <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_n;
         timer <= (state == IDLE || tick) ? '0 : timer + 16'd1;
         idx <= state == DATA ? idx + 3'(tick) : '0;
         shreg <= pop ? mem[rd_ptr] : shreg;
         rd_ptr <= rd_ptr + AW'(pop);
         wr_ptr <= wr_ptr + AW'(accept);
         count <= count + CW'(accept) - CW'(pop);
         overflow <= (push && !accept) ? 1'b1 : clr ? 1'b0 : overflow;
      end
   end
   always_ff @(posedge i_clk) begin
      if (accept && !i_rst) mem[wr_ptr] <= i_wr_data[7:0];
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized and directed checks of mmio_uart_tx against a queue-based line model.
module tb_mmio_uart_tx;
   localparam int CPB = 4;
   localparam int DEPTH = 4;
   localparam logic [15:0] BASE = 16'h0400;
   localparam logic [15:0] STAT = 16'h0401;
`ifdef UART_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] wr_data = '0;
   logic wr_en = 1'b0;
   logic [15:0] rd_data;
   logic tx;
   int errors = 0;
   int checks = 0;
   mmio_uart_tx #(.p_BASE_ADDR(BASE), .p_CLKS_PER_BIT(CPB), .p_FIFO_DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wr_data(wr_data),
      .i_wr_en(wr_en), .o_rd_data(rd_data), .o_tx(tx)
   );
   always #5 clk = ~clk;
   // model: a byte queue plus the per-cycle line levels of the frame in flight
   logic [7:0] q[$];
   logic wave[$];
   logic m_ovf = 1'b0;
   logic [7:0] mb;
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         wave.delete();
         m_ovf = 1'b0;
      end else begin
         if (wave.size() > 0) void'(wave.pop_front());
         if (wave.size() == 0 && q.size() > 0) begin
            mb = q.pop_front();
            repeat (CPB) wave.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (CPB) wave.push_back(mb[i]);
`ifdef UART_PARITY_EN
            repeat (CPB) wave.push_back(^mb);
`endif
            repeat (CPB) wave.push_back(1'b1);
         end
         if (wr_en && addr == BASE) begin
            if (q.size() < DEPTH) q.push_back(wr_data[7:0]);
            else m_ovf = 1'b1;
         end
         if (wr_en && addr == STAT) m_ovf = 1'b0;
      end
   end
   function automatic logic m_tx();
      return wave.size() > 0 ? wave[0] : 1'b1;
   endfunction
   function automatic logic [15:0] m_status();
      return {12'b0, m_ovf, wave.size() != 0, q.size() == 0, q.size() == DEPTH};
   endfunction
   function automatic logic [15:0] m_rd(input logic [15:0] a);
      return a == STAT ? m_status() : 16'h0000;
   endfunction
   task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we);
      addr = a;
      wr_data = d;
      wr_en = we;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) drive(16'h0000, 16'h0000, 1'b0);
      drive(BASE, 16'h00AA, 1'b1);
      rst = 1'b0;
      drive(STAT, 16'h0000, 1'b0);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++;
      if (rd_data !== 16'h0002) begin errors++; $display("FAIL reset_status: got %h expected 0002", rd_data); end
      addr = BASE;
      #1;
      checks++;
      if (rd_data !== 16'h0000) begin errors++; $display("FAIL txdata_read: got %h expected 0000", rd_data); end
   endtask
   task automatic test_single();
      drive(BASE, 16'hFF55, 1'b1);
      for (int i = 1; i <= FB * CPB + 4; i++) begin
         drive(STAT, 16'h0000, 1'b0);
         checks++;
         if (tx !== m_tx() || rd_data !== m_status()) begin
            errors++;
            $display("FAIL single_c%0d: tx=%b status=%h expected tx=%b status=%h", i, tx, rd_data, m_tx(), m_status());
         end
         if (i == 1) begin
            checks++;
            if (tx !== 1'b0) begin errors++; $display("FAIL single_start: got %b expected 0", tx); end
         end
         if (i == FB * CPB) begin
            checks++;
            if (rd_data[2] !== 1'b1) begin errors++; $display("FAIL single_busy_end: got %b expected 1", rd_data[2]); end
         end
         if (i == FB * CPB + 1) begin
            checks++;
            if (rd_data !== 16'h0002 || tx !== 1'b1) begin
               errors++;
               $display("FAIL single_idle: status=%h tx=%b expected 0002 1", rd_data, tx);
            end
         end
      end
   endtask
   task automatic test_parity();
      drive(BASE, 16'h0007, 1'b1);
      drive(BASE, 16'h0055, 1'b1);
      for (int i = 2; i <= 2 * FB * CPB + 4; i++) begin
         drive(STAT, 16'h0000, 1'b0);
         checks++;
         if (tx !== m_tx()) begin errors++; $display("FAIL parity_c%0d: got %b expected %b", i, tx, m_tx()); end
`ifdef UART_PARITY_EN
         if (i == 38) begin
            checks++;
            if (tx !== 1'b1) begin errors++; $display("FAIL parity_07: got %b expected 1", tx); end
         end
         if (i == 82) begin
            checks++;
            if (tx !== 1'b0) begin errors++; $display("FAIL parity_55: got %b expected 0", tx); end
         end
`endif
      end
   endtask
   task automatic test_overflow();
      int busy_cnt = 0;
      for (int j = 0; j < 6; j++) drive(BASE, 16'h00A1 + 16'(j), 1'b1);
      addr = STAT;
      wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data !== 16'h000D) begin errors++; $display("FAIL ovf_status: got %h expected 000D", rd_data); end
      drive(STAT, 16'hFFFF, 1'b1);
      addr = STAT;
      wr_en = 1'b0;
      #1;
      checks++;
      if (rd_data !== 16'h0005) begin errors++; $display("FAIL ovf_clear: got %h expected 0005", rd_data); end
      for (int i = 0; i < 5 * FB * CPB + 10; i++) begin
         drive(STAT, 16'h0000, 1'b0);
         busy_cnt += int'(rd_data[2]);
         checks++;
         if (tx !== m_tx() || rd_data !== m_status()) begin
            errors++;
            $display("FAIL ovf_c%0d: tx=%b status=%h expected tx=%b status=%h", i, tx, rd_data, m_tx(), m_status());
         end
      end
      checks++;
      if (busy_cnt != 5 * FB * CPB - 6) begin
         errors++;
         $display("FAIL ovf_no_gap: busy cycles %0d expected %0d", busy_cnt, 5 * FB * CPB - 6);
      end
   endtask
   task automatic test_decode();
      logic [15:0] probe [3] = '{16'h0402, 16'h03FF, BASE};
      for (int j = 0; j < 3; j++) begin
         addr = probe[j];
         #1;
         checks++;
         if (rd_data !== 16'h0000) begin errors++; $display("FAIL decode_rd_%h: got %h expected 0000", probe[j], rd_data); end
      end
      drive(16'h0402, 16'h0033, 1'b1);
      drive(16'h03FF, 16'h0044, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive(STAT, 16'h0000, 1'b0);
         checks++;
         if (tx !== 1'b1 || rd_data !== 16'h0002) begin
            errors++;
            $display("FAIL decode_idle_c%0d: tx=%b status=%h expected 1 0002", i, tx, rd_data);
         end
      end
   endtask
   task automatic test_reset_mid();
      drive(BASE, 16'h00F0, 1'b1);
      drive(BASE, 16'h0011, 1'b1);
      drive(BASE, 16'h0022, 1'b1);
      repeat (16) drive(STAT, 16'h0000, 1'b0);
      checks++;
      if (tx !== m_tx() || rd_data !== m_status()) begin
         errors++;
         $display("FAIL mid_before: tx=%b status=%h expected tx=%b status=%h", tx, rd_data, m_tx(), m_status());
      end
      rst = 1'b1;
      drive(STAT, 16'h0000, 1'b0);
      rst = 1'b0;
      checks++;
      if (tx !== 1'b1 || rd_data !== 16'h0002) begin
         errors++;
         $display("FAIL mid_reset: tx=%b status=%h expected 1 0002", tx, rd_data);
      end
      for (int i = 0; i < 2 * FB * CPB; i++) begin
         drive(STAT, 16'h0000, 1'b0);
         checks++;
         if (tx !== 1'b1 || rd_data !== 16'h0002) begin
            errors++;
            $display("FAIL mid_after_c%0d: tx=%b status=%h expected 1 0002", i, tx, rd_data);
         end
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         int r = $urandom_range(0, 99);
         int wp = i < 1500 ? 20 : 3;
         logic [15:0] d = 16'($urandom);
         if (r < wp) drive(BASE, d, 1'b1);
         else if (r < wp + 3) drive(STAT, d, 1'b1);
         else if (r < wp + 6) drive(r[0] ? 16'($urandom_range(16'h0402, 16'hFFFF)) : 16'($urandom_range(0, 16'h03FF)), d, 1'b1);
         else drive(r[1] ? STAT : (r[0] ? BASE : 16'($urandom)), d, 1'b0);
         checks++;
         if (tx !== m_tx() || rd_data !== m_rd(addr)) begin
            errors++;
            $display("FAIL random_c%0d: tx=%b rd=%h expected tx=%b rd=%h", i, tx, rd_data, m_tx(), m_rd(addr));
         end
      end
   endtask
   initial begin
      test_reset();
      test_single();
      test_parity();
      test_overflow();
      test_decode();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
